dvp_pixel_tx: RTL and testbench

DVP_PIXEL_TX -- requirements
Module: dvp_pixel_tx

---
 rtl/dvp_pkg.sv | 32 +++
 rtl/dvp_tx_timing.sv | 115 +++++++++++
 rtl/dvp_pixel_tx.sv | 99 +++++++++
 tb/tb_dvp_pixel_tx.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_pkg.sv
// Shared DVP definitions: FSM state encoding, default video timing and the
// sync-signal bundle used by both the TX and RX paths.
package dvp_pkg;

    localparam int unsigned DVP_DATA_W_DEF  = 8;
    localparam int unsigned RGB_PXL_W_DEF   = 16;
    localparam int unsigned H_ACTIVE_DEF    = 640;
    localparam int unsigned V_ACTIVE_DEF    = 480;
    localparam int unsigned H_BLANK_DEF     = 144;
    localparam int unsigned HSYNC_W_DEF     = 64;
    localparam int unsigned VSYNC_LINES_DEF = 3;
    localparam int unsigned VBP_LINES_DEF   = 17;
    localparam int unsigned VFP_LINES_DEF   = 10;

    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] ST_VSYNC  = 3'd1;
    localparam logic [ST_W-1:0] ST_VBP    = 3'd2;
    localparam logic [ST_W-1:0] ST_ACTIVE = 3'd3;
    localparam logic [ST_W-1:0] ST_VFP    = 3'd4;

    typedef struct packed {
        logic vsync;
        logic hsync;
        logic href;
    } dvp_sync_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dvp_tx_timing.sv
// DVP transmit timing: pclk divider, horizontal/line counters, frame FSM and
// registered sync outputs. Everything advances only on pclk falling edges.
module dvp_tx_timing
    import dvp_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
    parameter int unsigned H_BLANK     = H_BLANK_DEF,
    parameter int unsigned HSYNC_W     = HSYNC_W_DEF,
    parameter int unsigned VSYNC_LINES = VSYNC_LINES_DEF,
    parameter int unsigned VBP_LINES   = VBP_LINES_DEF,
    parameter int unsigned VFP_LINES   = VFP_LINES_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      start_i,
    output logic      pclk_o,
    output logic      pxl_slot_o,
    output logic      href_nxt_o,
    output logic      odd_nxt_o,
    output dvp_sync_t sync_o,
    output logic      frame_done_o
);

    localparam int unsigned H_TOTAL   = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned H_W       = $clog2(H_TOTAL);
    localparam int unsigned MAX_LINES = max_u(max_u(V_ACTIVE, VSYNC_LINES),
                                              max_u(VBP_LINES, VFP_LINES));
    localparam int unsigned L_W       = $clog2(MAX_LINES) + 1;

    localparam logic [H_W-1:0] H_LAST  = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] ACT_END = H_W'(2 * H_ACTIVE);
    localparam logic [H_W-1:0] HS_END  = H_W'(2 * H_ACTIVE + HSYNC_W - 1);

    logic            pclk_q, pclk_d;
    logic [ST_W-1:0] state_q, state_d;
    logic [H_W-1:0]  h_cnt_q, h_cnt_d;
    logic [L_W-1:0]  line_q, line_d, line_last;
    logic            done_q, done_d;
    dvp_sync_t       sync_q, sync_d;

    always_comb begin
        case (state_q)
            ST_VSYNC:  line_last = L_W'(VSYNC_LINES - 1);
            ST_VBP:    line_last = L_W'(VBP_LINES - 1);
            ST_ACTIVE: line_last = L_W'(V_ACTIVE - 1);
            default:   line_last = L_W'(VFP_LINES - 1);
        endcase
    end

    // pclk_q high means the coming clk edge is the pclk falling edge.
    always_comb begin
        pclk_d  = ~pclk_q;
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        line_d  = line_q;
        done_d  = 1'b0;
        if (pclk_q) begin
            if (state_q == ST_IDLE) begin
                if (start_i) begin
                    state_d = ST_VSYNC;
                end
            end else if (h_cnt_q != H_LAST) begin
                h_cnt_d = h_cnt_q + 1'b1;
            end else begin
                h_cnt_d = '0;
                if (line_q != line_last) begin
                    line_d = line_q + 1'b1;
                end else begin
                    line_d = '0;
                    case (state_q)
                        ST_VSYNC:  state_d = ST_VBP;
                        ST_VBP:    state_d = ST_ACTIVE;
                        ST_ACTIVE: state_d = ST_VFP;
                        default: begin
                            state_d = start_i ? ST_VSYNC : ST_IDLE;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end
        end

        // Decoded from next state so the pins are registered with no extra latency.
        sync_d.vsync = (state_d == ST_VSYNC);
        sync_d.hsync = (state_d != ST_IDLE) && (h_cnt_d >= ACT_END) && (h_cnt_d <= HS_END);
        sync_d.href  = (state_d == ST_ACTIVE) && (h_cnt_d < ACT_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pclk_q  <= 1'b0;
            state_q <= ST_IDLE;
            h_cnt_q <= '0;
            line_q  <= '0;
            done_q  <= 1'b0;
            sync_q  <= '0;
        end else begin
            pclk_q  <= pclk_d;
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            line_q  <= line_d;
            done_q  <= done_d;
            sync_q  <= sync_d;
        end
    end

    assign pclk_o       = pclk_q;
    assign pxl_slot_o   = pclk_q && sync_d.href && !h_cnt_d[0];
    assign href_nxt_o   = sync_d.href;
    assign odd_nxt_o    = h_cnt_d[0];
    assign sync_o       = sync_q;
    assign frame_done_o = done_q;

endmodule

// File: rtl/dvp_pixel_tx.sv
// RGB565 to 8-bit DVP transmitter: pixel handshake and high/low byte mux on
// top of the shared timing generator.
module dvp_pixel_tx
    import dvp_pkg::*;
#(
    parameter int unsigned DVP_DATA_W  = DVP_DATA_W_DEF,
    parameter int unsigned RGB_PXL_W   = RGB_PXL_W_DEF,
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
    parameter int unsigned H_BLANK     = H_BLANK_DEF,
    parameter int unsigned HSYNC_W     = HSYNC_W_DEF,
    parameter int unsigned VSYNC_LINES = VSYNC_LINES_DEF,
    parameter int unsigned VBP_LINES   = VBP_LINES_DEF,
    parameter int unsigned VFP_LINES   = VFP_LINES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [RGB_PXL_W-1:0]  rgb_pxl_i,
    input  logic                  rgb_pxl_vld_i,
    output logic                  rgb_pxl_rdy_o,
    output logic                  dvp_pclk_o,
    output logic [DVP_DATA_W-1:0] dvp_d_o,
    output logic                  dvp_href_o,
    output logic                  dvp_vsync_o,
    output logic                  dvp_hsync_o,
    output logic                  frame_done_o,
    output logic                  underrun_o
);

    dvp_sync_t             sync;
    logic                  pxl_slot;
    logic                  href_nxt;
    logic                  odd_nxt;
    logic [DVP_DATA_W-1:0] hi_q, hi_d;
    logic [DVP_DATA_W-1:0] lo_q, lo_d;
    logic [DVP_DATA_W-1:0] d_q, d_d;
    logic                  underrun_q, underrun_d;

    dvp_tx_timing #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .H_BLANK     (H_BLANK),
        .HSYNC_W     (HSYNC_W),
        .VSYNC_LINES (VSYNC_LINES),
        .VBP_LINES   (VBP_LINES),
        .VFP_LINES   (VFP_LINES)
    ) u_timing (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .pclk_o       (dvp_pclk_o),
        .pxl_slot_o   (pxl_slot),
        .href_nxt_o   (href_nxt),
        .odd_nxt_o    (odd_nxt),
        .sync_o       (sync),
        .frame_done_o (frame_done_o)
    );

    // A missing pixel is replaced by zeros so line timing never stalls.
    always_comb begin
        hi_d       = hi_q;
        lo_d       = lo_q;
        underrun_d = underrun_q;
        if (pxl_slot) begin
            if (rgb_pxl_vld_i) begin
                hi_d = rgb_pxl_i[2*DVP_DATA_W-1:DVP_DATA_W];
                lo_d = rgb_pxl_i[DVP_DATA_W-1:0];
            end else begin
                hi_d       = '0;
                lo_d       = '0;
                underrun_d = 1'b1;
            end
        end
        d_d = href_nxt ? (odd_nxt ? lo_d : hi_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q       <= '0;
            lo_q       <= '0;
            d_q        <= '0;
            underrun_q <= 1'b0;
        end else begin
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            d_q        <= d_d;
            underrun_q <= underrun_d;
        end
    end

    assign rgb_pxl_rdy_o = pxl_slot;
    assign dvp_d_o       = d_q;
    assign dvp_href_o    = sync.href;
    assign dvp_vsync_o   = sync.vsync;
    assign dvp_hsync_o   = sync.hsync;
    assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_dvp_pixel_tx.sv
// Directed bench for dvp_pixel_tx with a small frame (12 pclk lines, 5 lines
// per frame); samples DVP outputs on pclk rising edges like a real receiver.
module tb_dvp_pixel_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [15:0] rgb_pxl_i;
    logic        rgb_pxl_vld_i;
    logic        rgb_pxl_rdy_o;
    logic        dvp_pclk_o;
    logic [7:0]  dvp_d_o;
    logic        dvp_href_o;
    logic        dvp_vsync_o;
    logic        dvp_hsync_o;
    logic        frame_done_o;
    logic        underrun_o;

    always #5 clk = ~clk;

    dvp_pixel_tx #(
        .DVP_DATA_W  (8),
        .RGB_PXL_W   (16),
        .H_ACTIVE    (4),
        .V_ACTIVE    (2),
        .H_BLANK     (4),
        .HSYNC_W     (2),
        .VSYNC_LINES (1),
        .VBP_LINES   (1),
        .VFP_LINES   (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .rgb_pxl_i     (rgb_pxl_i),
        .rgb_pxl_vld_i (rgb_pxl_vld_i),
        .rgb_pxl_rdy_o (rgb_pxl_rdy_o),
        .dvp_pclk_o    (dvp_pclk_o),
        .dvp_d_o       (dvp_d_o),
        .dvp_href_o    (dvp_href_o),
        .dvp_vsync_o   (dvp_vsync_o),
        .dvp_hsync_o   (dvp_hsync_o),
        .frame_done_o  (frame_done_o),
        .underrun_o    (underrun_o)
    );

    logic [15:0] tab [8] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                             16'h0FED, 16'hCBA9, 16'h8765, 16'h4321};

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pixel source: idx counts accepted pixels; mode 0 = valid except one
    // optional drop at idx == drop_at, mode 1 = vld toggles every clk.
    int unsigned idx     = 0;
    int unsigned drop_at = 1000;
    int unsigned mode    = 0;
    bit          dropped = 1'b0;

    initial begin
        logic s_rdy, s_vld;
        rgb_pxl_i     = tab[0];
        rgb_pxl_vld_i = 1'b1;
        forever begin
            @(negedge clk);
            s_rdy = rgb_pxl_rdy_o;
            s_vld = rgb_pxl_vld_i;
            @(posedge clk);
            #1;
            if (s_rdy) begin
                if (s_vld) idx++;
                else if (idx == drop_at) dropped = 1'b1;
            end
            if (mode == 0) rgb_pxl_vld_i = !(idx == drop_at && !dropped);
            else           rgb_pxl_vld_i = dvp_pclk_o;
            rgb_pxl_i = rgb_pxl_vld_i ? tab[idx % 8] : 16'hDEAD;
        end
    end

    int unsigned done_cnt = 0;
    always @(negedge clk) if (frame_done_o) done_cnt++;

    int unsigned edge_chg  = 0;
    int unsigned edge_viol = 0;
    always @(posedge clk) begin
        logic [10:0] pre;
        logic        pp;
        pre = {dvp_d_o, dvp_href_o, dvp_vsync_o, dvp_hsync_o};
        pp  = dvp_pclk_o;
        #1;
        if ({dvp_d_o, dvp_href_o, dvp_vsync_o, dvp_hsync_o} != pre) begin
            edge_chg++;
            if (!pp) edge_viol++;
        end
    end

    logic [7:0] cap_d    [0:60];
    logic       cap_href [0:60];
    logic       cap_vs   [0:60];
    logic       cap_hs   [0:60];
    logic       cap_done60;

    task automatic step_pclk();
        int unsigned n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (dvp_pclk_o !== 1'b1 && n < 4);
        if (dvp_pclk_o !== 1'b1) check("pclk_rise_timeout", 32'(dvp_pclk_o), 32'd1);
    endtask

    task automatic wait_vsync();
        int unsigned n = 0;
        do begin
            step_pclk();
            n++;
        end while (dvp_vsync_o !== 1'b1 && n < 200);
        check("vsync_wait", 32'(dvp_vsync_o), 32'd1);
    endtask

    task automatic sample(input int i);
        cap_d[i]    = dvp_d_o;
        cap_href[i] = dvp_href_o;
        cap_vs[i]   = dvp_vsync_o;
        cap_hs[i]   = dvp_hsync_o;
    endtask

    // Current pclk-rise sample is frame sample 0; captures samples 0..60.
    task automatic capture_frame();
        sample(0);
        for (int i = 1; i <= 60; i++) begin
            step_pclk();
            sample(i);
        end
        cap_done60 = frame_done_o;
    endtask

    task automatic check_frame(input string tag, input int base, input int drop_slot,
                               input logic next_vs, input int unsigned done0);
        int          nvs    = 0;
        int          nhs    = 0;
        int          nhref  = 0;
        int          nstray = 0;
        int          k;
        int          pos;
        logic [15:0] px;
        for (int i = 0; i < 60; i++) begin
            if (cap_vs[i])   nvs++;
            if (cap_hs[i])   nhs++;
            if (cap_href[i]) nhref++;
            if (!cap_href[i] && cap_d[i] != 8'h00) nstray++;
        end
        check({tag, "_vsync_cnt"}, 32'(nvs), 32'd12);
        check({tag, "_vsync_last"}, 32'(cap_vs[11]), 32'd1);
        check({tag, "_vsync_end"}, 32'(cap_vs[12]), 32'd0);
        check({tag, "_next_vsync"}, 32'(cap_vs[60]), 32'(next_vs));
        check({tag, "_hsync_cnt"}, 32'(nhs), 32'd10);
        check({tag, "_hsync_h7"}, 32'(cap_hs[7]), 32'd0);
        check({tag, "_hsync_h8"}, 32'(cap_hs[8]), 32'd1);
        check({tag, "_hsync_h9"}, 32'(cap_hs[9]), 32'd1);
        check({tag, "_hsync_h10"}, 32'(cap_hs[10]), 32'd0);
        check({tag, "_hsync_l4"}, 32'(cap_hs[56]), 32'd1);
        check({tag, "_href_cnt"}, 32'(nhref), 32'd16);
        check({tag, "_href_pre"}, 32'(cap_href[23]), 32'd0);
        check({tag, "_href_first"}, 32'(cap_href[24]), 32'd1);
        check({tag, "_href_last"}, 32'(cap_href[43]), 32'd1);
        check({tag, "_href_blank"}, 32'(cap_href[32]), 32'd0);
        check({tag, "_d_zero_blank"}, 32'(nstray), 32'd0);
        k = base;
        for (int s = 0; s < 8; s++) begin
            if (s == drop_slot) begin
                px = 16'h0000;
            end else begin
                px = tab[k % 8];
                k++;
            end
            pos = 24 + (s / 4) * 12 + (s % 4) * 2;
            check({tag, "_byte_hi"}, 32'(cap_d[pos]), 32'(px[15:8]));
            check({tag, "_byte_lo"}, 32'(cap_d[pos + 1]), 32'(px[7:0]));
        end
        check({tag, "_done_pulses"}, done_cnt - done0, 32'd1);
        check({tag, "_done_width"}, 32'(cap_done60), 32'd0);
    endtask

    initial begin
        int unsigned done0;
        int unsigned idx0;
        int          nz;
        rst_n   = 1'b1;
        start_i = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_pclk", 32'(dvp_pclk_o), 32'd0);
        check("rst_d", 32'(dvp_d_o), 32'd0);
        check("rst_href", 32'(dvp_href_o), 32'd0);
        check("rst_vsync", 32'(dvp_vsync_o), 32'd0);
        check("rst_hsync", 32'(dvp_hsync_o), 32'd0);
        check("rst_rdy", 32'(rgb_pxl_rdy_o), 32'd0);
        check("rst_done", 32'(frame_done_o), 32'd0);
        check("rst_underrun", 32'(underrun_o), 32'd0);

        start_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_edge1_pclk", 32'(dvp_pclk_o), 32'd1);
        check("rel_edge1_vsync", 32'(dvp_vsync_o), 32'd0);
        @(posedge clk); #1;
        check("rel_edge2_pclk", 32'(dvp_pclk_o), 32'd0);
        check("rel_edge2_vsync", 32'(dvp_vsync_o), 32'd1);

        // Scenario 1: continuous valid pixels.
        step_pclk();
        done0 = done_cnt;
        capture_frame();
        check_frame("s1", 0, -1, 1'b1, done0);
        check("s1_underrun", 32'(underrun_o), 32'd0);

        // Scenario 2: third pixel of the frame missing.
        drop_at = 10;
        done0 = done_cnt;
        capture_frame();
        check_frame("s2", 8, 2, 1'b1, done0);
        check("s2_underrun", 32'(underrun_o), 32'd1);

        // Scenario 3: start dropped during VSYNC; frame completes, then idle.
        start_i = 1'b0;
        done0 = done_cnt;
        capture_frame();
        check_frame("s3", 15, -1, 1'b0, done0);
        nz = 0;
        for (int i = 0; i < 20; i++) begin
            step_pclk();
            if (dvp_d_o != 8'h00 || dvp_href_o || dvp_vsync_o || dvp_hsync_o || rgb_pxl_rdy_o)
                nz++;
        end
        check("s3_idle_quiet", 32'(nz), 32'd0);
        check("s3_underrun_sticky", 32'(underrun_o), 32'd1);

        // Scenario 4: asynchronous reset mid-ACTIVE, then restart.
        start_i = 1'b1;
        wait_vsync();
        for (int i = 0; i < 26; i++) step_pclk();
        check("s4_pre_href", 32'(dvp_href_o), 32'd1);
        check("s4_pre_d", 32'(dvp_d_o), 32'h12);
        check("s4_pre_underrun", 32'(underrun_o), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("s4_rst_pclk", 32'(dvp_pclk_o), 32'd0);
        check("s4_rst_d", 32'(dvp_d_o), 32'd0);
        check("s4_rst_href", 32'(dvp_href_o), 32'd0);
        check("s4_rst_vsync", 32'(dvp_vsync_o), 32'd0);
        check("s4_rst_hsync", 32'(dvp_hsync_o), 32'd0);
        check("s4_rst_rdy", 32'(rgb_pxl_rdy_o), 32'd0);
        check("s4_rst_underrun", 32'(underrun_o), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_vsync();
        done0 = done_cnt;
        capture_frame();
        check_frame("s4", 25, -1, 1'b1, done0);
        check("s4_underrun", 32'(underrun_o), 32'd0);

        // Scenario 5: vld toggling every clk, high only in rdy cycles.
        mode    = 1;
        start_i = 1'b0;
        idx0    = idx;
        done0   = done_cnt;
        capture_frame();
        check_frame("s5", 33, -1, 1'b0, done0);
        check("s5_consumed", idx - idx0, 32'd8);
        check("s5_underrun", 32'(underrun_o), 32'd0);

        // Scenario 6: every DVP output change happened on a pclk falling edge.
        check("s6_edge_violations", edge_viol, 32'd0);
        check("s6_edges_seen", 32'(edge_chg != 0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
